diners_ring: RTL and testbench

DINERS_RING -- requirements
Module: diners_ring

---
 rtl/diners_ring.sv | 157 +++++++++++++++
 tb/tb_diners_ring.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diners_ring.sv
// diners_ring: ring of N dining philosophers (THINKING/HUNGRY/EATING/READING)
// with neighbour-based fork arbitration and a READING wave that travels
// around the ring.
//
// Parameters:
//   N          number of philosophers (3..64)
//   MODE       0 = fixed asymmetric rule, 1 = rotating priority token
//   STARVE_MAX hungry-cycle count at which starve_flag asserts (1..255)
//   EAT_MAX    forced-release limit in EATING cycles, 0 = disabled
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   hungry_req  per-philosopher THINKING->HUNGRY request
//   done_req    per-philosopher EATING->THINKING request
//   read_start  per-philosopher THINKING->READING injection
//   state_o     packed states, 2 bits per philosopher
//   eating      per-philosopher EATING decode
//   starve_flag per-philosopher registered starvation flag
//   token       priority holder index (always 0 when MODE=0)
//   safety_err  sticky adjacent-EATING violation flag
module diners_ring #(
    parameter int N          = 8,
    parameter int MODE       = 0,
    parameter int STARVE_MAX = 15,
    parameter int EAT_MAX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     hungry_req,
    input  logic [N-1:0]     done_req,
    input  logic [N-1:0]     read_start,
    output logic [2*N-1:0]   state_o,
    output logic [N-1:0]     eating,
    output logic [N-1:0]     starve_flag,
    output logic [5:0]       token,
    output logic             safety_err
);

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        HUNGRY   = 2'd1,
        EATING   = 2'd2,
        READING  = 2'd3
    } phil_state_t;

    localparam int unsigned NU        = N;
    localparam logic [7:0]  STARVE_TH = 8'(STARVE_MAX);
    localparam logic [31:0] EAT_LIM   = 32'(EAT_MAX);
    localparam logic [5:0]  TOK_LAST  = 6'(N - 1);

    phil_state_t st       [N];
    phil_state_t st_nxt   [N];
    logic [7:0]  hcnt     [N];
    logic [7:0]  hcnt_nxt [N];
    logic [15:0] ecnt     [N];
    logic [15:0] ecnt_nxt [N];
    logic [N-1:0] sflag, sflag_nxt;
    logic [5:0]  tok, tok_nxt;
    logic        err, err_nxt;
    logic        tok_hungry, tok_grant;
    // Set on the first edge after reset release; state only moves once it is
    // high, so the first state change lands on the second edge.
    logic        run;

    function automatic int unsigned left_of(int unsigned i);
        return (i + 1) % NU;
    endfunction

    function automatic int unsigned right_of(int unsigned i);
        return (i + NU - 1) % NU;
    endfunction

    // ecnt holds completed EATING cycles; +1 counts the cycle in progress, so
    // a philosopher leaves on the edge that ends its EAT_MAX-th eating cycle.
    function automatic logic eat_limit(logic [15:0] c);
        return (EAT_MAX > 0) && (({16'd0, c} + 32'd1) >= EAT_LIM);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '{default: THINKING};
            hcnt  <= '{default: '0};
            ecnt  <= '{default: '0};
            sflag <= '0;
            tok   <= '0;
            err   <= 1'b0;
            run   <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            st    <= st_nxt;
            hcnt  <= hcnt_nxt;
            ecnt  <= ecnt_nxt;
            sflag <= sflag_nxt;
            tok   <= tok_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        st_nxt     = st;
        hcnt_nxt   = hcnt;
        ecnt_nxt   = ecnt;
        sflag_nxt  = sflag;
        tok_nxt    = tok;
        err_nxt    = err;
        tok_hungry = 1'b0;
        tok_grant  = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            case (st[i])
                READING: begin
                    if (st[left_of(i)] == THINKING) st_nxt[i] = THINKING;
                end
                THINKING: begin
                    if (st[right_of(i)] == READING || read_start[i]) st_nxt[i] = READING;
                    else if (hungry_req[i])                             st_nxt[i] = HUNGRY;
                end
                EATING: begin
                    if (done_req[i] || eat_limit(ecnt[i])) st_nxt[i] = THINKING;
                end
                HUNGRY: begin
                    if (st[left_of(i)] != EATING && st[right_of(i)] != EATING &&
                        (st[right_of(i)] != HUNGRY || (MODE == 1 && tok == 6'(i))))
                        st_nxt[i] = EATING;
                end
                default: ;
            endcase

            hcnt_nxt[i]  = (st[i] == HUNGRY) ? ((hcnt[i] == 8'hFF) ? 8'hFF : hcnt[i] + 8'd1) : '0;
            sflag_nxt[i] = (hcnt_nxt[i] >= STARVE_TH);
            // Any non-EATING cycle zeroes the count, so entry always starts at 0.
            ecnt_nxt[i]  = (st[i] == EATING) ? ((ecnt[i] == '1) ? '1 : ecnt[i] + 16'd1) : '0;

            if (st[i] == EATING && st[left_of(i)] == EATING) err_nxt = 1'b1;

            if (tok == 6'(i)) begin
                tok_hungry = (st[i] == HUNGRY);
                tok_grant  = (st_nxt[i] == EATING);
            end
        end
        if (MODE == 1 && (!tok_hungry || tok_grant))
            tok_nxt = (tok == TOK_LAST) ? '0 : tok + 6'd1;
    end

    always_comb begin
        state_o = '0;
        eating  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            state_o[2*i +: 2] = st[i];
            eating[i]         = (st[i] == EATING);
        end
        starve_flag = sflag;
        token       = tok;
        safety_err  = err;
    end

endmodule

// File: tb/tb_diners_ring.sv
// tb_diners_ring: runs three N=4 rings side by side on shared stimulus
//   u0: MODE=0, STARVE_MAX=15, EAT_MAX=0
//   u1: MODE=1, STARVE_MAX=15, EAT_MAX=0
//   u2: MODE=0, STARVE_MAX=4,  EAT_MAX=3
// A behavioural ring model pushes expected outputs into a scoreboard each
// cycle; the popped entries are compared after the edge. Scenario tasks add
// their own targeted checks.
module tb_diners_ring;

    localparam int NK = 3;
    localparam int MODE_K  [NK] = '{0, 1, 0};
    localparam int STARV_K [NK] = '{15, 15, 4};
    localparam int EATM_K  [NK] = '{0, 0, 3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] hungry_req = '0;
    logic [3:0] done_req = '0;
    logic [3:0] read_start = '0;

    logic [7:0] so  [NK];
    logic [3:0] eo  [NK];
    logic [3:0] sfo [NK];
    logic [5:0] to  [NK];
    logic       ero [NK];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] st;
        logic [3:0] eat;
        logic [3:0] sf;
        logic [5:0] tok;
        logic       err;
    } exp_t;
    exp_t sb [$];

    int ms [NK][4];
    int mh [NK][4];
    int me [NK][4];
    int mtok [NK];
    bit msf [NK][4];
    bit merr [NK];
    bit mrun;

    always #5 clk = ~clk;

    diners_ring #(.N(4), .MODE(0), .STARVE_MAX(15), .EAT_MAX(0)) u0 (
        .clk(clk), .rst_n(rst_n), .hungry_req(hungry_req), .done_req(done_req),
        .read_start(read_start), .state_o(so[0]), .eating(eo[0]),
        .starve_flag(sfo[0]), .token(to[0]), .safety_err(ero[0]));

    diners_ring #(.N(4), .MODE(1), .STARVE_MAX(15), .EAT_MAX(0)) u1 (
        .clk(clk), .rst_n(rst_n), .hungry_req(hungry_req), .done_req(done_req),
        .read_start(read_start), .state_o(so[1]), .eating(eo[1]),
        .starve_flag(sfo[1]), .token(to[1]), .safety_err(ero[1]));

    diners_ring #(.N(4), .MODE(0), .STARVE_MAX(4), .EAT_MAX(3)) u2 (
        .clk(clk), .rst_n(rst_n), .hungry_req(hungry_req), .done_req(done_req),
        .read_start(read_start), .state_o(so[2]), .eating(eo[2]),
        .starve_flag(sfo[2]), .token(to[2]), .safety_err(ero[2]));

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < 4; i++) begin
                ms[k][i] = 0; mh[k][i] = 0; me[k][i] = 0; msf[k][i] = 0;
            end
            mtok[k] = 0;
            merr[k] = 0;
        end
        mrun = 0;
        sb.delete();
    endtask

    // Advance the model by one edge using the currently driven inputs, then
    // push the expected post-edge outputs of every instance.
    task automatic model_step();
        int ns [4];
        int l, r;
        exp_t e;
        if (!mrun) begin
            mrun = 1;
        end else begin
            for (int k = 0; k < NK; k++) begin
                for (int i = 0; i < 4; i++) begin
                    l = (i + 1) % 4;
                    r = (i + 3) % 4;
                    ns[i] = ms[k][i];
                    case (ms[k][i])
                        0: if (ms[k][r] == 3 || read_start[i]) ns[i] = 3;
                           else if (hungry_req[i]) ns[i] = 1;
                        1: if (ms[k][l] != 2 && ms[k][r] != 2 &&
                               (ms[k][r] != 1 || (MODE_K[k] == 1 && mtok[k] == i))) ns[i] = 2;
                        2: if (done_req[i] || (EATM_K[k] > 0 && me[k][i] + 1 >= EATM_K[k])) ns[i] = 0;
                        default: if (ms[k][l] == 0) ns[i] = 0;
                    endcase
                    if (ms[k][i] == 2 && ms[k][l] == 2) merr[k] = 1;
                end
                if (MODE_K[k] == 1 && (ms[k][mtok[k]] != 1 || ns[mtok[k]] == 2))
                    mtok[k] = (mtok[k] + 1) % 4;
                for (int i = 0; i < 4; i++) begin
                    mh[k][i]  = (ms[k][i] == 1) ? ((mh[k][i] < 255) ? mh[k][i] + 1 : 255) : 0;
                    msf[k][i] = (mh[k][i] >= STARV_K[k]);
                    me[k][i]  = (ms[k][i] == 2) ? me[k][i] + 1 : 0;
                    ms[k][i]  = ns[i];
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            e.st = '0; e.eat = '0; e.sf = '0;
            for (int i = 0; i < 4; i++) begin
                e.st[2*i +: 2] = 2'(ms[k][i]);
                e.eat[i]       = (ms[k][i] == 2);
                e.sf[i]        = msf[k][i];
            end
            e.tok = 6'(mtok[k]);
            e.err = merr[k];
            sb.push_back(e);
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty inst %0d got 0 entries required 1", k);
            end else begin
                e = sb.pop_front();
                if (so[k] !== e.st) begin
                    errors++;
                    $display("FAIL sb_state_o inst %0d got %h required %h", k, so[k], e.st);
                end
                checks++;
                if (eo[k] !== e.eat) begin
                    errors++;
                    $display("FAIL sb_eating inst %0d got %b required %b", k, eo[k], e.eat);
                end
                checks++;
                if (sfo[k] !== e.sf) begin
                    errors++;
                    $display("FAIL sb_starve inst %0d got %b required %b", k, sfo[k], e.sf);
                end
                checks++;
                if (to[k] !== e.tok) begin
                    errors++;
                    $display("FAIL sb_token inst %0d got %0d required %0d", k, to[k], e.tok);
                end
                checks++;
                if (ero[k] !== e.err) begin
                    errors++;
                    $display("FAIL sb_safety inst %0d got %b required %b", k, ero[k], e.err);
                end
            end
        end
    endtask

    task automatic do_reset();
        hungry_req = '0; done_req = '0; read_start = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if ({so[k], eo[k], sfo[k], to[k], ero[k]} !== '0) begin
                errors++;
                $display("FAIL reset_async inst %0d got %h required 0", k,
                         {so[k], eo[k], sfo[k], to[k], ero[k]});
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // first edge after release only arms the ring; hungry_req must not act
        hungry_req = 4'b0001;
        cycle();
        hungry_req = '0;
        checks++;
        if (so[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_edge got %h required 00", so[0]);
        end
        repeat (2) cycle();
    endtask

    task automatic test_single_grant();
        hungry_req = 4'b0001;
        cycle();
        hungry_req = '0;
        checks++;
        if (so[0] !== 8'h01) begin
            errors++;
            $display("FAIL grant_hungry got %h required 01", so[0]);
        end
        cycle();
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (eo[k] !== 4'b0001) begin
                errors++;
                $display("FAIL grant_eating inst %0d got %b required 0001", k, eo[k]);
            end
        end
        done_req = 4'b0001;
        cycle();
        done_req = '0;
        checks++;
        if (so[0] !== 8'h00 || ero[0] !== 1'b0) begin
            errors++;
            $display("FAIL grant_done got %h/%b required 00/0", so[0], ero[0]);
        end
        repeat (2) cycle();
    endtask

    task automatic test_deadlock();
        bit seen2;
        int n;
        n = 0;
        while (mtok[1] != 3 && n < 8) begin
            cycle();
            n++;
        end
        checks++;
        if (mtok[1] != 3) begin
            errors++;
            $display("FAIL deadlock_token_align got %0d required 3", mtok[1]);
        end
        hungry_req = 4'hF;
        cycle();
        hungry_req = '0;
        for (int j = 1; j <= 15; j++) begin
            cycle();
            if (j == 1) begin
                checks++;
                if (eo[1] !== 4'b0001) begin
                    errors++;
                    $display("FAIL token_grant got %b required 0001", eo[1]);
                end
            end
            if (j == 3 || j == 4) begin
                checks++;
                if (sfo[2] !== ((j == 4) ? 4'hF : 4'h0)) begin
                    errors++;
                    $display("FAIL starve_u2 cyc %0d got %b", j, sfo[2]);
                end
            end
            if (j == 14 || j == 15) begin
                checks++;
                if (sfo[0] !== ((j == 15) ? 4'hF : 4'h0) || eo[0] !== 4'h0) begin
                    errors++;
                    $display("FAIL starve_u0 cyc %0d got %b/%b", j, sfo[0], eo[0]);
                end
            end
        end
        done_req = 4'hF;
        seen2 = 0;
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (eo[1][2]) seen2 = 1;
        end
        done_req = '0;
        checks++;
        if (!seen2 || ero[1] !== 1'b0) begin
            errors++;
            $display("FAIL token_ph2_progress got seen=%0d err=%b required 1/0", seen2, ero[1]);
        end
    endtask

    task automatic test_reading();
        logic [7:0] exp_wave [4];
        exp_wave = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        do_reset();
        repeat (3) cycle();
        read_start = 4'b0001;
        for (int j = 0; j < 4; j++) begin
            cycle();
            read_start = '0;
            checks++;
            if (so[0] !== exp_wave[j]) begin
                errors++;
                $display("FAIL read_wave hop %0d got %h required %h", j, so[0], exp_wave[j]);
            end
        end
        repeat (4) cycle();
    endtask

    task automatic test_eat_limit();
        do_reset();
        repeat (2) cycle();
        hungry_req = 4'b0010;
        cycle();
        hungry_req = '0;
        cycle();
        for (int j = 1; j <= 3; j++) begin
            cycle();
            checks++;
            if (eo[2] !== ((j == 3) ? 4'b0000 : 4'b0010) || eo[0] !== 4'b0010) begin
                errors++;
                $display("FAIL eat_limit cyc %0d got u2=%b u0=%b", j, eo[2], eo[0]);
            end
        end
        done_req = 4'b0010;
        cycle();
        done_req = '0;
        cycle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        repeat (2) cycle();
        hungry_req = 4'b0100;
        cycle();
        hungry_req = 4'b1000;
        cycle();
        hungry_req = '0;
        repeat (2) cycle();
        checks++;
        if (so[0] !== 8'h60) begin
            errors++;
            $display("FAIL midop_setup got %h required 60", so[0]);
        end
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if ({so[k], eo[k], sfo[k], to[k], ero[k]} !== '0) begin
                errors++;
                $display("FAIL midop_reset inst %0d got %h required 0", k,
                         {so[k], eo[k], sfo[k], to[k], ero[k]});
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic test_random();
        do_reset();
        repeat (2) cycle();
        for (int j = 0; j < 120; j++) begin
            hungry_req = 4'($urandom_range(0, 15));
            done_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            read_start = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            cycle();
        end
        hungry_req = '0; done_req = '0; read_start = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_grant();
        test_deadlock();
        test_reading();
        test_eat_limit();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
